param_miss_handler: RTL and testbench



---
 rtl/param_miss_handler.sv | 178 +++++++++++++++++
 tb/tb_param_miss_handler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_miss_handler.sv
// Set-associative miss handler: fetches a block in beats, writes it into the data array,
// updates metadata and returns the missed word. Define PMH_CRITICAL_WORD_FIRST_EN for wrap-order fill.
module param_miss_handler #(
  parameter int NUM_WAYS        = 4,
  parameter int SET_BITS        = 4,
  parameter int TAG_BITS        = 8,
  parameter int WORD_WIDTH      = 20,
  parameter int WORDS_PER_BLOCK = 16,
  parameter int BEAT_WORDS      = 2,
  localparam int OFF   = $clog2(WORDS_PER_BLOCK),
  localparam int BEATS = WORDS_PER_BLOCK / BEAT_WORDS,
  localparam int BI    = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int A     = TAG_BITS + SET_BITS + OFF,
  localparam int WI    = $clog2(NUM_WAYS),
  localparam int BWB   = $clog2(BEAT_WORDS),
  localparam int DAW   = SET_BITS + WI + BI,
  localparam int BW    = BEAT_WORDS * WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_valid,
  input  logic                  i_hit,
  input  logic [A-1:0]          i_addr,
  input  logic [NUM_WAYS-1:0]   i_way_valid,
  input  logic [WI-1:0]         i_lru_way,
  output logic                  o_ready,
  output logic                  o_mem_req_valid,
  output logic [A-1:0]          o_mem_req_addr,
  input  logic                  i_mem_req_ready,
  input  logic [BW-1:0]         i_mem_data,
  input  logic                  i_mem_data_valid,
  output logic                  o_mem_ready,
  output logic                  o_da_valid,
  output logic [DAW-1:0]        o_da_addr,
  output logic [BW-1:0]         o_da_data,
  input  logic                  i_da_ready,
  output logic                  o_meta_valid,
  output logic [SET_BITS-1:0]   o_meta_set,
  output logic [WI-1:0]         o_meta_way,
  output logic [TAG_BITS-1:0]   o_meta_tag,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic                  o_word_valid,
  output logic                  o_miss_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_META = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]            state_reg, state_next;
  logic [A-1:0]          addr_reg;
  logic [WI-1:0]         victim_reg;
  logic [BI:0]           rcv_cnt_reg, wr_cnt_reg;
  logic                  da_valid_reg;
  logic [DAW-1:0]        da_addr_reg;
  logic [BW-1:0]         da_data_reg;
  logic [WORD_WIDTH-1:0] word_reg;

  logic [WI-1:0]         victim_way;
  logic                  victim_found;
  logic [TAG_BITS-1:0]   tag_l;
  logic [SET_BITS-1:0]   set_l;
  logic [OFF-1:0]        off_l;
  logic [BI-1:0]         crit_beat, start_beat, cur_beat;
  logic [OFF-1:0]        req_off;
  int                    word_idx;
  logic                  start_miss, mem_xfer, da_fire, last_write;

  assign tag_l    = addr_reg[A-1 -: TAG_BITS];
  assign set_l    = addr_reg[OFF +: SET_BITS];
  assign off_l    = addr_reg[OFF-1:0];
  assign crit_beat = BI'(off_l >> BWB);
  assign word_idx = int'(off_l) % BEAT_WORDS;

`ifdef PMH_CRITICAL_WORD_FIRST_EN
  assign start_beat = crit_beat;
  assign req_off    = off_l & ~OFF'(BEAT_WORDS - 1);
`else
  assign start_beat = '0;
  assign req_off    = '0;
`endif

  // Memory returns beats in wrap order, so the n-th received beat lands at start+n.
  assign cur_beat = BI'((int'(start_beat) + int'(rcv_cnt_reg)) % BEATS);

  always_comb begin
    victim_way   = i_lru_way;
    victim_found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!victim_found && !i_way_valid[w]) begin
        victim_way   = WI'(w);
        victim_found = 1'b1;
      end
    end
  end

  assign start_miss  = (state_reg == S_IDLE) && i_valid && !i_hit;
  // The write register may only take a new beat once its current beat is leaving.
  assign o_mem_ready = (state_reg == S_FILL) && (rcv_cnt_reg != (BI+1)'(BEATS)) &&
                       !(da_valid_reg && !i_da_ready);
  assign mem_xfer    = o_mem_ready && i_mem_data_valid;
  assign da_fire     = da_valid_reg && i_da_ready;
  assign last_write  = da_fire && (wr_cnt_reg == (BI+1)'(BEATS - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start_miss)      state_next = S_REQ;
      S_REQ:  if (i_mem_req_ready) state_next = S_FILL;
      S_FILL: if (last_write)      state_next = S_META;
      S_META: if (i_da_ready)      state_next = S_RESP;
      S_RESP:                      state_next = S_IDLE;
      default:                     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      victim_reg   <= '0;
      rcv_cnt_reg  <= '0;
      wr_cnt_reg   <= '0;
      da_valid_reg <= 1'b0;
      da_addr_reg  <= '0;
      da_data_reg  <= '0;
      word_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (start_miss) begin
        addr_reg    <= i_addr;
        victim_reg  <= victim_way;
        rcv_cnt_reg <= '0;
        wr_cnt_reg  <= '0;
      end
      if (mem_xfer) begin
        rcv_cnt_reg  <= rcv_cnt_reg + (BI+1)'(1);
        da_valid_reg <= 1'b1;
        da_addr_reg  <= {set_l, victim_reg, cur_beat};
        da_data_reg  <= i_mem_data;
        if (cur_beat == crit_beat)
          word_reg <= i_mem_data[word_idx*WORD_WIDTH +: WORD_WIDTH];
      end else if (da_fire) begin
        da_valid_reg <= 1'b0;
      end
      if (da_fire)
        wr_cnt_reg <= wr_cnt_reg + (BI+1)'(1);
    end
  end

`ifdef PMH_CRITICAL_WORD_FIRST_EN
  logic word_pulse_reg;
  // The critical beat is always the first one received.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) word_pulse_reg <= 1'b0;
    else      word_pulse_reg <= mem_xfer && (rcv_cnt_reg == '0);
  end
  assign o_word_valid = word_pulse_reg;
`else
  assign o_word_valid = (state_reg == S_RESP);
`endif

  assign o_ready         = (state_reg == S_IDLE);
  assign o_miss_state    = (state_reg != S_IDLE);
  assign o_mem_req_valid = (state_reg == S_REQ);
  assign o_mem_req_addr  = {addr_reg[A-1:OFF], req_off};
  assign o_da_valid      = da_valid_reg;
  assign o_da_addr       = da_addr_reg;
  assign o_da_data       = da_data_reg;
  assign o_meta_valid    = (state_reg == S_META) && i_da_ready;
  assign o_meta_set      = set_l;
  assign o_meta_way      = victim_reg;
  assign o_meta_tag      = tag_l;
  assign o_word          = word_reg;

endmodule

// File: tb/tb_param_miss_handler.sv
// Randomized bench for param_miss_handler against a block-level model of each miss.
// Follows PMH_CRITICAL_WORD_FIRST_EN the same way the design does.
module tb_param_miss_handler;
  localparam int NW = 4, SB = 4, TB = 8, WW = 20, WPB = 16, BWD = 2;
  localparam int OFF = 4, BEATS = 8, BI = 3, A = 16, WI = 2, DAW = 9;

  logic clk = 1'b0;
  logic arst;
  logic i_valid, i_hit;
  logic [A-1:0] i_addr;
  logic [NW-1:0] i_way_valid;
  logic [WI-1:0] i_lru_way;
  logic o_ready, o_mem_req_valid, i_mem_req_ready;
  logic [A-1:0] o_mem_req_addr;
  logic [2*WW-1:0] i_mem_data, o_da_data;
  logic i_mem_data_valid, o_mem_ready, o_da_valid, i_da_ready;
  logic [DAW-1:0] o_da_addr;
  logic o_meta_valid;
  logic [SB-1:0] o_meta_set;
  logic [WI-1:0] o_meta_way;
  logic [TB-1:0] o_meta_tag;
  logic [WW-1:0] o_word;
  logic o_word_valid, o_miss_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_miss_handler #(
    .NUM_WAYS(NW), .SET_BITS(SB), .TAG_BITS(TB), .WORD_WIDTH(WW),
    .WORDS_PER_BLOCK(WPB), .BEAT_WORDS(BWD)
  ) dut (
    .clk(clk), .arst(arst), .i_valid(i_valid), .i_hit(i_hit), .i_addr(i_addr),
    .i_way_valid(i_way_valid), .i_lru_way(i_lru_way), .o_ready(o_ready),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_req_ready(i_mem_req_ready), .i_mem_data(i_mem_data),
    .i_mem_data_valid(i_mem_data_valid), .o_mem_ready(o_mem_ready),
    .o_da_valid(o_da_valid), .o_da_addr(o_da_addr), .o_da_data(o_da_data),
    .i_da_ready(i_da_ready), .o_meta_valid(o_meta_valid), .o_meta_set(o_meta_set),
    .o_meta_way(o_meta_way), .o_meta_tag(o_meta_tag), .o_word(o_word),
    .o_word_valid(o_word_valid), .o_miss_state(o_miss_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Contents of main memory: word w of block blk.
  function automatic logic [WW-1:0] mem_word(input logic [A-OFF-1:0] blk, input int w);
    logic [31:0] h;
    h = ({20'd0, blk} * 32'd40503 + 32'(w) * 32'd7919) ^ 32'h5A5A5;
    return h[WW-1:0];
  endfunction

  function automatic logic [2*WW-1:0] beat_data(input logic [A-OFF-1:0] blk, input int b);
    return {mem_word(blk, 2*b + 1), mem_word(blk, 2*b)};
  endfunction

  task automatic reset_abandon();
    int q_meta = 0, q_word = 0, q_busy = 0;
    i_valid = 1'b0;
    i_mem_data_valid = 1'b0;
    i_da_ready = 1'b1;
    arst = 1'b1;
    #1;
    chk("rst_async", {o_ready, o_miss_state, o_mem_req_valid, o_mem_ready,
                      o_da_valid, o_meta_valid, o_word_valid}, 7'b1000000);
    @(negedge clk);
    arst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      i_mem_data_valid = 1'($urandom_range(0, 1));
      i_mem_data = 40'({$urandom, $urandom});
      #1;
      if (o_meta_valid) q_meta++;
      if (o_word_valid) q_word++;
      if (o_miss_state || o_da_valid || o_mem_ready) q_busy++;
    end
    i_mem_data_valid = 1'b0;
    chk("rst_no_meta", q_meta, 0);
    chk("rst_no_word", q_word, 0);
    chk("rst_idle", q_busy, 0);
    $display("reset mid-fill: abandoned");
  endtask

  // dr_mode: 0 data array always ready, 1 random ready, 2 three-cycle stall on beat write 2
  task automatic run_miss(input logic [A-1:0] addr, input logic [NW-1:0] wv,
                          input logic [WI-1:0] lru, input int dr_mode, input int rst_after);
    logic [TB-1:0] tag;
    logic [SB-1:0] set;
    logic [A-OFF-1:0] blk;
    logic [A-1:0] exp_req;
    logic [DAW-1:0] qa[$];
    logic [2*WW-1:0] qd[$];
    logic [WW-1:0] exp_word;
    logic [2*WW-1:0] prev_data = '0;
    int off, ew, start, crit, cyc;
    int mem_k = 0, wr_done = 0, meta_n = 0, word_n = 0, word_cyc_exp = -1, stall = 0;
    int err_bp = 0, err_stab = 0, err_ms = 0, err_req = 0;
    bit req_acc = 0, req_pend = 0, xfer_pend = 0, offering = 0, prev_stall = 0, done = 0;

    tag = addr[A-1 -: TB];
    set = addr[OFF +: SB];
    blk = addr[A-1:OFF];
    off = int'(addr[OFF-1:0]);
    ew = int'(lru);
    for (int w = NW - 1; w >= 0; w--) if (!wv[w]) ew = w;
    crit = off / BWD;
`ifdef PMH_CRITICAL_WORD_FIRST_EN
    start = crit;
    exp_req = {blk, OFF'(crit * BWD)};
`else
    start = 0;
    exp_req = {blk, {OFF{1'b0}}};
`endif
    for (int k = 0; k < BEATS; k++) begin
      qa.push_back({set, WI'(ew), BI'((start + k) % BEATS)});
      qd.push_back(beat_data(blk, (start + k) % BEATS));
    end
    exp_word = mem_word(blk, off);

    @(negedge clk);
    i_valid = 1'b1; i_hit = 1'b0; i_addr = addr; i_way_valid = wv; i_lru_way = lru;
    i_mem_req_ready = 1'b0; i_mem_data_valid = 1'b0; i_da_ready = 1'b1;
    #1;
    chk("accept_ready", o_ready, 1);

    for (cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (req_pend) begin req_acc = 1; req_pend = 0; end
      if (xfer_pend) begin mem_k++; offering = 0; xfer_pend = 0; end
      if (rst_after >= 0 && mem_k == rst_after) begin
        reset_abandon();
        return;
      end
      // Lookups arriving mid-miss must be ignored.
      i_valid = (meta_n == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_hit = 1'($urandom_range(0, 1));
      i_addr = A'($urandom);
      i_way_valid = NW'($urandom);
      i_lru_way = WI'($urandom);
      i_mem_req_ready = 1'($urandom_range(0, 1));
      if (req_acc && mem_k < BEATS) begin
        if (!offering && $urandom_range(0, 3) != 0) offering = 1;
        i_mem_data_valid = offering;
        i_mem_data = beat_data(blk, (start + mem_k) % BEATS);
      end else begin
        i_mem_data_valid = 1'($urandom_range(0, 1));
        i_mem_data = 40'({$urandom, $urandom});
      end
      if (dr_mode == 1) i_da_ready = ($urandom_range(0, 3) != 0);
      else if (dr_mode == 2 && o_da_valid && wr_done == 2 && stall < 3) begin
        i_da_ready = 1'b0;
        stall++;
      end else i_da_ready = 1'b1;
      #1;
      if (prev_stall && o_da_data !== prev_data) err_stab++;
      prev_stall = o_da_valid && !i_da_ready;
      prev_data = o_da_data;
      if (o_da_valid && !i_da_ready && o_mem_ready) err_bp++;
      if ((!req_acc || meta_n > 0) && o_mem_ready) err_bp++;
      if (o_ready == o_miss_state) err_ms++;
      if (o_mem_req_valid) begin
        if (req_acc || o_mem_req_addr !== exp_req) err_req++;
        if (i_mem_req_ready) req_pend = 1;
      end
      if (o_da_valid && i_da_ready) begin
        if (qa.size() == 0) err_bp++;
        else begin
          chk("da_addr", o_da_addr, qa.pop_front());
          chk("da_data", o_da_data, qd.pop_front());
        end
        wr_done++;
      end
      if (i_mem_data_valid && o_mem_ready) begin
        xfer_pend = 1;
`ifdef PMH_CRITICAL_WORD_FIRST_EN
        if (mem_k == 0) word_cyc_exp = cyc + 1;
`endif
      end
      if (o_meta_valid) begin
        meta_n++;
        chk("meta", {o_meta_set, o_meta_way, o_meta_tag}, {set, WI'(ew), tag});
`ifndef PMH_CRITICAL_WORD_FIRST_EN
        word_cyc_exp = cyc + 1;
`endif
      end
      if (o_word_valid) begin
        word_n++;
        chk("word", o_word, exp_word);
        chk("word_time", cyc, word_cyc_exp);
      end
      if (!o_ready && meta_n == 0 && !o_miss_state) err_ms++;
      if (o_ready && meta_n > 0) done = 1;
    end
    i_valid = 1'b0;
    chk("miss_done", done, 1);
    chk("meta_count", meta_n, 1);
    chk("word_count", word_n, 1);
    chk("writes_left", qa.size(), 0);
    chk("req_addr", err_req, 0);
    chk("mem_ready_rule", err_bp, 0);
    chk("da_data_stable", err_stab, 0);
    chk("miss_state", err_ms, 0);
    if (dr_mode == 2) chk("stall_cycles", stall, 3);
    $display("miss addr=%h way=%0d mode=%0d writes=%0d cycles=%0d", addr, ew, dr_mode, wr_done, cyc);
  endtask

  task automatic hit_idle();
    int err = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      i_valid = (c < 5);
      i_hit = 1'b1;
      i_addr = A'($urandom);
      i_way_valid = NW'($urandom);
      i_mem_data_valid = 1'($urandom_range(0, 1));
      #1;
      if (o_miss_state || o_mem_req_valid || !o_ready || o_mem_ready ||
          o_da_valid || o_meta_valid || o_word_valid) err++;
    end
    i_valid = 1'b0;
    i_mem_data_valid = 1'b0;
    chk("hit_idle", err, 0);
    $display("hit lookups: no miss started");
  endtask

  initial begin
    arst = 1'b1;
    i_valid = 0; i_hit = 0; i_addr = '0; i_way_valid = '0; i_lru_way = '0;
    i_mem_req_ready = 0; i_mem_data = '0; i_mem_data_valid = 0; i_da_ready = 0;
    #2;
    chk("reset_outs", {o_ready, o_miss_state, o_mem_req_valid, o_mem_ready,
                       o_da_valid, o_meta_valid, o_word_valid}, 7'b1000000);
    repeat (2) @(negedge clk);
    arst = 1'b0;

    run_miss(16'hA536, 4'b0000, 2'd0, 0, -1);
    run_miss(16'h3C95, 4'b1111, 2'd2, 1, -1);
    run_miss(16'h7E20, 4'b1011, 2'd1, 2, -1);
    hit_idle();
    run_miss(16'h5D7B, 4'b0111, 2'd0, 0, -1);
    run_miss(16'hC3A4, 4'b0001, 2'd3, 1, 4);
    run_miss(16'h4E1B, 4'b1111, 2'd1, 1, -1);
    for (int n = 0; n < 20; n++) begin
      logic [NW-1:0] wv;
      wv = ($urandom_range(0, 1) != 0) ? 4'hF : NW'($urandom);
      run_miss(A'($urandom), wv, WI'($urandom), 1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
